// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory wait tracking and timeout abort. Control outputs are combinational.
module multicycle_ctrl #(
   parameter int WAIT_MAX = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic       mem_ready,
   input  logic       zero,
   output logic [2:0] state,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic       sign_or_zero,
   output logic       instr_done,
   output logic       mem_err
);

   localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SLI  = 3'b001;
   localparam logic [2:0] OP_J    = 3'b010;
   localparam logic [2:0] OP_JAL  = 3'b011;
   localparam logic [2:0] OP_LW   = 3'b100;
   localparam logic [2:0] OP_SW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_ADDI = 3'b111;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       sign_or_zero;
      logic       instr_done;
      logic       mem_err;
   } ctrl_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [CNT_W-1:0]   wait_q, wait_d;
   ctrl_t              ctl, ctl_o;
   logic               mem_phase, stall, timeout;

   // {alu_op, alu_src, sign_or_zero} for the ALU-using opcodes.
   function automatic logic [3:0] exec_alu(input logic [2:0] op);
      logic [3:0] r;
      case (op)
         OP_ADD:                r = 4'b00_0_1;
         OP_SLI:                r = 4'b10_1_0;
         OP_LW, OP_SW, OP_ADDI: r = 4'b11_1_1;
         OP_BEQ:                r = 4'b01_0_1;
         default:               r = 4'b00_0_1;
      endcase
      return r;
   endfunction

   assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
   assign stall     = mem_phase && !mem_ready;
   // mem_ready in the cycle the counter hits WAIT_MAX still completes normally.
   assign timeout   = stall && (wait_q == CNT_W'(WAIT_MAX));
   assign wait_d    = (stall && !timeout) ? wait_q + 1'b1 : '0;

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      ctl              = '0;
      ctl.sign_or_zero = 1'b1;

      if (timeout) begin
         ctl.mem_err = 1'b1;
         state_d     = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               ctl.mem_read = 1'b1;
               if (mem_ready) begin
                  ctl.ir_write = 1'b1;
                  ctl.pc_write = 1'b1;
                  ctl.pc_src   = 2'b00;
                  state_d      = S_DECODE;
               end
            end

            S_DECODE: begin
               op_d = opcode;
               case (opcode)
                  OP_J: begin
                     ctl.pc_write   = 1'b1;
                     ctl.pc_src     = 2'b10;
                     ctl.instr_done = 1'b1;
                     state_d        = S_FETCH;
                  end
                  OP_JAL: begin
                     ctl.pc_write   = 1'b1;
                     ctl.pc_src     = 2'b10;
                     ctl.reg_write  = 1'b1;
                     ctl.reg_dst    = 2'b10;
                     ctl.mem_to_reg = 2'b10;
                     ctl.instr_done = 1'b1;
                     state_d        = S_FETCH;
                  end
                  default: state_d = S_EXEC;
               endcase
            end

            S_EXEC: begin
               {ctl.alu_op, ctl.alu_src, ctl.sign_or_zero} = exec_alu(op_q);
               case (op_q)
                  OP_BEQ: begin
                     ctl.pc_write   = zero;
                     ctl.pc_src     = 2'b01;
                     ctl.instr_done = 1'b1;
                     state_d        = S_FETCH;
                  end
                  OP_LW, OP_SW:           state_d = S_MEM;
                  OP_ADD, OP_SLI, OP_ADDI: state_d = S_WB;
                  default:                state_d = S_FETCH;
               endcase
            end

            S_MEM: begin
               ctl.alu_op  = 2'b11;
               ctl.alu_src = 1'b1;
               case (op_q)
                  OP_LW: begin
                     ctl.mem_read = 1'b1;
                     if (mem_ready) state_d = S_WB;
                  end
                  OP_SW: begin
                     ctl.mem_write = 1'b1;
                     if (mem_ready) begin
                        ctl.instr_done = 1'b1;
                        state_d        = S_FETCH;
                     end
                  end
                  default: state_d = S_FETCH;
               endcase
            end

            S_WB: begin
               ctl.reg_write  = 1'b1;
               ctl.instr_done = 1'b1;
               state_d        = S_FETCH;
               case (op_q)
                  OP_ADD: ctl.reg_dst = 2'b01;
                  OP_SLI, OP_ADDI: begin
                     ctl.reg_dst = 2'b00;
                     {ctl.alu_op, ctl.alu_src, ctl.sign_or_zero} = exec_alu(op_q);
                  end
                  OP_LW:   ctl.mem_to_reg = 2'b01;
                  default: ctl.reg_dst    = 2'b00;
               endcase
            end

            default: state_d = S_FETCH;
         endcase
      end
   end

   // Reset masks every strobe immediately, without waiting for a clock edge.
   always_comb begin
      ctl_o = ctl;
      if (reset) begin
         ctl_o              = '0;
         ctl_o.sign_or_zero = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= 3'b000;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
      end
   end

   assign state        = state_q;
   assign ir_write     = ctl_o.ir_write;
   assign pc_write     = ctl_o.pc_write;
   assign pc_src       = ctl_o.pc_src;
   assign mem_read     = ctl_o.mem_read;
   assign mem_write    = ctl_o.mem_write;
   assign reg_write    = ctl_o.reg_write;
   assign reg_dst      = ctl_o.reg_dst;
   assign mem_to_reg   = ctl_o.mem_to_reg;
   assign alu_op       = ctl_o.alu_op;
   assign alu_src      = ctl_o.alu_src;
   assign sign_or_zero = ctl_o.sign_or_zero;
   assign instr_done   = ctl_o.instr_done;
   assign mem_err      = ctl_o.mem_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-step reference model compared every
// cycle, plus directed latency/boundary scenarios and randomized instructions.
module tb_multicycle_ctrl;

   localparam int WM = 8;
   localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4;

   typedef struct packed {
      logic [2:0] st;
      logic       ir_w;
      logic       pc_w;
      logic [1:0] pc_src;
      logic       mr;
      logic       mw;
      logic       rw;
      logic [1:0] rd;
      logic [1:0] m2r;
      logic [1:0] aluop;
      logic       asrc;
      logic       soz;
      logic       done;
      logic       err;
   } outs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] opcode;
   logic       mem_ready, zero;
   logic [2:0] state;
   logic       ir_write, pc_write, mem_read, mem_write, reg_write;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_op;
   logic       alu_src, sign_or_zero, instr_done, mem_err;

   int n_err = 0;
   int n_chk = 0;

   multicycle_ctrl #(.WAIT_MAX(WM)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
      .state(state), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_src(alu_src),
      .sign_or_zero(sign_or_zero), .instr_done(instr_done), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   outs_t dut_v;
   assign dut_v = {state, ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
                   reg_dst, mem_to_reg, alu_op, alu_src, sign_or_zero, instr_done, mem_err};

   // ---------------- reference model ----------------
   // Cycles per instruction with no memory waits.
   function automatic int n_steps(input logic [2:0] op);
      case (op)
         3'd2, 3'd3: return 2;
         3'd6:       return 3;
         3'd4:       return 5;
         default:    return 4;
      endcase
   endfunction

   function automatic int phase_at(input logic [2:0] op, input int step);
      if (step == 0) return PF;
      if (step == 1) return PD;
      if (step == 2) return PE;
      if (step == 3) return (op == 3'd4 || op == 3'd5) ? PM : PW;
      return PW;
   endfunction

   // Strobes for a phase/opcode; instr_done and timeout are applied by the caller.
   function automatic outs_t expect_out(input int ph, input logic [2:0] op,
                                        input logic mr, input logic z);
      outs_t e;
      e = '0;
      e.st  = 3'(ph);
      e.soz = 1'b1;
      if (ph == PF) begin
         e.mr = 1'b1;
         if (mr) begin e.ir_w = 1'b1; e.pc_w = 1'b1; end
      end else if (ph == PD) begin
         if (op == 3'd2 || op == 3'd3) begin e.pc_w = 1'b1; e.pc_src = 2'b10; end
         if (op == 3'd3) begin e.rw = 1'b1; e.rd = 2'b10; e.m2r = 2'b10; end
      end else if (ph == PE) begin
         if (op == 3'd1) begin e.aluop = 2'b10; e.asrc = 1'b1; e.soz = 1'b0; end
         if (op == 3'd4 || op == 3'd5 || op == 3'd7) begin e.aluop = 2'b11; e.asrc = 1'b1; end
         if (op == 3'd6) begin e.aluop = 2'b01; e.pc_w = z; e.pc_src = 2'b01; end
      end else if (ph == PM) begin
         e.aluop = 2'b11; e.asrc = 1'b1;
         e.mr = (op == 3'd4);
         e.mw = (op == 3'd5);
      end else begin
         e.rw = 1'b1;
         if (op == 3'd0) e.rd = 2'b01;
         if (op == 3'd1) begin e.aluop = 2'b10; e.asrc = 1'b1; e.soz = 1'b0; end
         if (op == 3'd7) begin e.aluop = 2'b11; e.asrc = 1'b1; end
         if (op == 3'd4) e.m2r = 2'b01;
      end
      return e;
   endfunction

   int         m_step = 0;
   int         m_wait = 0;
   int         m_ph;
   logic [2:0] m_op = 3'd0;
   logic [2:0] m_cur;
   outs_t      m_e;

   always @(negedge clk) begin
      if (reset) begin
         m_e = '0; m_e.soz = 1'b1;
         m_step = 0; m_wait = 0; m_op = 3'd0;
      end else begin
         m_cur = (m_step == 1) ? opcode : m_op;
         m_ph  = phase_at(m_cur, m_step);
         m_e   = expect_out(m_ph, m_cur, mem_ready, zero);
         if ((m_ph == PF || m_ph == PM) && !mem_ready && m_wait == WM) begin
            m_e = '0; m_e.st = 3'(m_ph); m_e.soz = 1'b1; m_e.err = 1'b1;
            m_step = 0; m_wait = 0;
         end else if ((m_ph == PF || m_ph == PM) && !mem_ready) begin
            m_wait++;
         end else begin
            m_wait = 0;
            if (m_step == 1) m_op = opcode;
            if (m_step + 1 == n_steps(m_cur)) begin
               m_e.done = 1'b1;
               m_step = 0;
            end else begin
               m_step++;
            end
         end
      end
      n_chk++;
      if (dut_v !== m_e) begin
         n_err++;
         $display("FAIL model_cmp t=%0t got=%05h exp=%05h", $time, dut_v, m_e);
      end
   end

   // ---------------- driver and checks ----------------
   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic mr, input logic z);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      opcode    = op;
      mem_ready = mr;
      zero      = z;
      @(negedge clk);
   endtask

   outs_t rec[40];
   int    r_end, r_kind;

   // Runs one instruction: fw FETCH wait cycles, mw MEM wait cycles.
   task automatic run_instr(input logic [2:0] op, input int fw, input int mw_in, input logic z);
      int         mw, ms, ekind, ecyc;
      bit         is_mem;
      logic       mr, zz;
      logic [2:0] oc;
      is_mem = (op == 3'd4 || op == 3'd5);
      mw     = is_mem ? mw_in : 0;
      ms     = fw + 3;
      r_kind = 0;
      r_end  = -1;
      for (int i = 0; i < 40; i++) rec[i] = '0;
      for (int k = 0; k < 40; k++) begin
         if (k <= fw) mr = (k == fw);
         else if (is_mem && k >= ms) mr = (k >= ms + mw);
         else mr = 1'($urandom_range(0, 1));
         oc = (k == fw + 1) ? op : 3'($urandom_range(0, 7));
         zz = (k == fw + 2) ? z : 1'($urandom_range(0, 1));
         drive(oc, mr, zz);
         rec[k] = dut_v;
         if (mem_err) begin r_kind = 2; r_end = k; break; end
         if (instr_done) begin r_kind = 1; r_end = k; break; end
      end
      if (fw > WM) begin
         ekind = 2; ecyc = WM;
      end else if (is_mem && mw > WM) begin
         ekind = 2; ecyc = fw + 3 + WM;
      end else begin
         ekind = 1; ecyc = n_steps(op) - 1 + fw + mw;
      end
      check("instr_end_kind", r_kind, ekind);
      check("instr_end_cycle", r_end, ecyc);
   endtask

   int cnt;

   initial begin
      reset = 1'b1; opcode = 3'd0; mem_ready = 1'b1; zero = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_state", state, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_sign_or_zero", sign_or_zero, 1);
      check("rst_ir_write", ir_write, 0);

      // add, no waits: FETCH, DECODE, EXEC, WB
      run_instr(3'd0, 0, 0, 1'b0);
      check("add_st0", rec[0].st, 0);
      check("add_st1", rec[1].st, 1);
      check("add_st2", rec[2].st, 2);
      check("add_st3", rec[3].st, 4);
      check("add_wb_rw", rec[3].rw, 1);
      check("add_wb_rd", rec[3].rd, 1);
      cnt = 0;
      for (int k = 0; k < 4; k++) cnt += int'(rec[k].done);
      check("add_done_pulses", cnt, 1);

      // lw with three MEM wait cycles: 8 cycles total
      run_instr(3'd4, 0, 3, 1'b0);
      cnt = 0;
      for (int k = 3; k < 7; k++) cnt += int'(rec[k].mr && rec[k].st == 3'd3);
      check("lw_mem_read_cycles", cnt, 4);
      check("lw_wb_state", rec[7].st, 4);
      check("lw_wb_m2r", rec[7].m2r, 1);
      check("lw_total", r_end + 1, 8);

      // beq taken then not taken
      run_instr(3'd6, 0, 0, 1'b1);
      check("beq1_pc_write", rec[2].pc_w, 1);
      check("beq1_pc_src", rec[2].pc_src, 1);
      run_instr(3'd6, 0, 0, 1'b0);
      check("beq0_pc_write", rec[2].pc_w, 0);
      check("beq0_total", r_end + 1, 3);

      // jal completes in DECODE
      run_instr(3'd3, 0, 0, 1'b0);
      check("jal_pc_write", rec[1].pc_w, 1);
      check("jal_pc_src", rec[1].pc_src, 2);
      check("jal_reg_write", rec[1].rw, 1);
      check("jal_reg_dst", rec[1].rd, 2);
      check("jal_m2r", rec[1].m2r, 2);

      // sw timeout in MEM, then a normal instruction starts in FETCH
      run_instr(3'd5, 0, 20, 1'b0);
      check("sw_to_err", rec[11].err, 1);
      check("sw_to_mem_write", rec[11].mw, 0);
      check("sw_to_done", rec[11].done, 0);
      run_instr(3'd7, 0, 0, 1'b0);
      check("after_to_state", rec[0].st, 0);

      // mem_ready arriving exactly at the limit completes normally
      run_instr(3'd0, WM, 0, 1'b0);
      run_instr(3'd5, 0, WM, 1'b0);
      // FETCH timeout abandons the fetch
      run_instr(3'd1, WM + 3, 0, 1'b0);

      // addi: reset asserted asynchronously during WB
      drive(3'($urandom_range(0, 7)), 1'b1, 1'b0);
      drive(3'd7, 1'($urandom_range(0, 1)), 1'b0);
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      check("addi_wb_rw", reg_write, 1);
      #1 reset = 1'b1;
      #1;
      check("rst_mid_rw", reg_write, 0);
      check("rst_mid_state", state, 0);
      check("rst_mid_done", instr_done, 0);
      check("rst_mid_mem_read", mem_read, 0);
      @(negedge clk);
      run_instr(3'd2, 0, 0, 1'b0);

      // randomized instruction stream
      for (int n = 0; n < 60; n++) begin
         int fw, mw;
         fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(WM - 1, WM + 2)) : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(WM - 1, WM + 2)) : int'($urandom_range(0, 3));
         run_instr(3'($urandom_range(0, 7)), fw, mw, 1'($urandom_range(0, 1)));
      end

      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 8, SHALL set the maximum number of mem_ready-low cycles tolerated per memory access before abort.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be asynchronous, active-high.
REQ-004 opcode  in  3  instruction opcode from the instruction register: 000 add, 001 sli, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.
REQ-005 mem_ready  in  1  memory completes the current read/write this cycle.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-008 ir_write, pc_write  out  1 each  IR load strobe; PC load strobe.
REQ-009 pc_src  out  2  PC source: 00 PC+1, 01 branch target, 10 jump target.
REQ-010 mem_read, mem_write, reg_write  out  1 each  memory read/write request; register file write strobe.
REQ-011 reg_dst, mem_to_reg, alu_op  out  2 each  encodings identical to the single-cycle control decode.
REQ-012 alu_src, sign_or_zero  out  1 each  ALU B-operand select; 1 = sign-extend, 0 = zero-extend.
REQ-013 instr_done  out  1  one-cycle pulse in the final cycle of each completed instruction.
REQ-014 mem_err  out  1  one-cycle pulse on memory timeout.

Function
REQ-015 The FSM SHALL capture opcode into internal op_q on the DECODE clock edge; EXEC/MEM/WB decode SHALL use op_q only.
REQ-016 Outputs SHALL be combinational from state, op_q (opcode in DECODE), mem_ready, zero and the wait counter; any strobe not listed for a state SHALL be 0, with sign_or_zero=1 unless stated.
REQ-017 FETCH: mem_read=1; when mem_ready=1, ir_write=1, pc_write=1, pc_src=00, next state DECODE; else remain in FETCH.
REQ-018 DECODE, j: pc_write=1, pc_src=10, instr_done=1, next FETCH.
REQ-019 DECODE, jal: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1, next FETCH.
REQ-020 DECODE, all other opcodes: no strobes, next EXEC.
REQ-021 EXEC: alu_op/alu_src/sign_or_zero per op_q: add 00/0/1, sli 10/1/0, lw 11/1/1, sw 11/1/1, beq 01/0/1, addi 11/1/1.
REQ-022 EXEC, beq: branch asserted internally; pc_write=zero, pc_src=01, instr_done=1, next FETCH.
REQ-023 EXEC, lw/sw: next MEM; add/sli/addi: next WB.
REQ-024 MEM: alu_op=11, alu_src=1 held; lw asserts mem_read, sw asserts mem_write, until mem_ready=1.
REQ-025 MEM with mem_ready=1: lw next WB; sw asserts instr_done, next FETCH.
REQ-026 WB: reg_write=1; add reg_dst=01, mem_to_reg=00; sli/addi reg_dst=00, mem_to_reg=00 with EXEC ALU controls held; lw reg_dst=00, mem_to_reg=01; instr_done=1, next FETCH.
REQ-027 Latency at zero wait SHALL be: j/jal 2, beq 3, add/sli/addi/sw 4, lw 5 cycles; each mem_ready-low cycle adds one.
REQ-028 A wait counter SHALL increment each FETCH/MEM cycle with mem_ready=0, and clear on state change or mem_ready=1.
REQ-029 When the counter equals WAIT_MAX and mem_ready=0: mem_err=1, all strobes 0 that cycle, no instr_done, counter cleared, next FETCH (PC not advanced, instruction retried/abandoned).
REQ-030 mem_ready=1 in the timeout cycle SHALL take priority: normal completion, no mem_err.
REQ-031 mem_ready and zero SHALL be ignored in states that do not reference them.
REQ-032 Illegal state encodings (5-7) SHALL return to FETCH next cycle with all strobes 0.

Reset
REQ-033 While reset=1: state=FETCH, op_q=000, counter=0; every output 0 except sign_or_zero=1 and state=0, including mem_read.
REQ-034 Reset asserted mid-instruction SHALL immediately force these values; no partial writes complete; first FETCH request issued in the first cycle after deassertion.

Verification
REQ-035 Reset release, opcode=000, mem_ready=1 always -> states 0,1,2,4; reg_write=1 with reg_dst=01 in cycle 4; instr_done single pulse.
REQ-036 lw, mem_ready low 3 cycles in MEM -> mem_read held 4 MEM cycles, then WB with mem_to_reg=01; total 8 cycles.
REQ-037 beq with zero=1 then zero=0 -> pc_write=1/pc_src=01 in EXEC first case; pc_write=0 second; both done in 3 cycles.
REQ-038 jal -> DECODE cycle shows pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; next state FETCH.
REQ-039 sw, mem_ready held 0, WAIT_MAX=8 -> mem_err pulse on 9th MEM cycle, mem_write=0 that cycle, no instr_done, state FETCH next.
REQ-040 reset asserted asynchronously during WB of addi -> reg_write drops to 0 before next clock edge; state=0.
